alu16_arbiter: RTL and testbench
================================

Name: alu16_arbiter

Overview:
- Shares one 16-bit add/sub/and/or datapath between two requesters.
- Requests arrive on valid/ready channels; a round-robin arbiter grants one request at a time.
- Operands are registered and the result is computed in one execute cycle, then held on a single tagged response channel until it is accepted.
- Sits between instruction-issue logic and the ALU, and is the team's first sequenced ALU resource.

Parameters:
- W, 16, operand/result width in bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a command
- req0_ready  output  1  requester 0 command accepted this cycle
- req0_a  input  W  requester 0 operand a
- req0_b  input  W  requester 0 operand b
- req0_op  input  2  requester 0 op: 00 add, 01 sub (a-b), 10 and, 11 or
- req1_valid  input  1  requester 1 has a command
- req1_ready  output  1  requester 1 command accepted this cycle
- req1_a  input  W  requester 1 operand a
- req1_b  input  W  requester 1 operand b
- req1_op  input  2  requester 1 op, same encoding as req0_op
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer takes result
- rsp_data  output  W  result
- rsp_id  output  1  index of the requester that issued the result
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - State = IDLE.
  - rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0.
  - Operand registers = 0.
  - last_grant = 1, so requester 0 wins the first contention.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester. If both are valid, grant = ~last_grant.
  - reqN_ready = (state==IDLE) & reqN_valid & (grant==N). The ready outputs are combinational from valid, and never both high.
  - On accept: capture a, b, op and id into registers; last_grant <= id; go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (1 cycle):
  - rsp_data <= f(op_q, a_q, b_q) and rsp_id <= id_q.
  - rsp_valid <= 1; go to RESP.
- RESP:
  - rsp_valid, rsp_data and rsp_id are held stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid <= 0; go to IDLE.
  - Both reqN_ready are 0 throughout EXEC and RESP.
- Latency:
  - Accept in cycle N gives rsp_valid high from cycle N+2.
  - With rsp_ready tied high, the next accept is possible in cycle N+3. Peak throughput is 1 op per 3 cycles.
- Arithmetic:
  - All results are modulo 2^W.
  - sub is two's complement a + ~b + 1. Underflow wraps (0 - 1 = all ones).
  - and/or are bitwise.
- Input rules:
  - Operands and op are sampled only on the accept cycle. Input changes after accept have no effect.
  - A requester may drop valid before it is accepted. There is no penalty and no state change.
- Simultaneous events:
  - Both valid in IDLE: strict alternation across consecutive contended grants.
  - rsp_ready may be high before rsp_valid. It has no effect until RESP.
- Reset mid-operation: the in-flight command is discarded with no response, and all outputs return to reset values immediately (asynchronous).
- Invariant: no command is lost or duplicated. Every accept produces exactly one response handshake, unless a reset intervenes.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: adds outputs rsp_zero, rsp_neg and rsp_carry (each 1 bit). They are registered with rsp_data in EXEC and held in RESP.
  - rsp_zero = (result == 0).
  - rsp_neg = result[W-1].
  - rsp_carry = carry-out of a+b for add; carry-out of a+~b+1 for sub (1 means no borrow); 0 for and/or.
  - All three reset to 0.
- Not defined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then req0 add a=0x1234, b=0x0FED with rsp_ready=1 -> req0_ready high in cycle 0; rsp_valid in cycle 2 with rsp_data=0x2221, rsp_id=0; busy high in cycles 1-2.
- Both requesters valid continuously (req0 sub 0x0000-0x0001, req1 or 0xF0F0|0x0F0F) -> grants alternate 0,1,0,1; req0 results=0xFFFF; req1 results=0xFFFF with rsp_id=1. With ALU_FLAGS_EN, req0 result has rsp_carry=0 and rsp_neg=1.
- Backpressure: req1 and 0xFF00&0x0FF0, rsp_ready held low 5 cycles -> rsp_valid, rsp_data=0x0F00 and rsp_id stable throughout; req0_ready/req1_ready stay 0; accepted on the first rsp_ready cycle.
- Wrap: add 0xFFFF+0x0001 -> rsp_data=0x0000. With ALU_FLAGS_EN: rsp_zero=1, rsp_carry=1, rsp_neg=0.
- Operand change after accept: req0 add 5+3 accepted, then inputs change to 9+9 while valid stays high -> first response 0x0008; the second accept yields 0x0012.
- Reset asserted during RESP -> rsp_valid drops asynchronously, no response is issued; after release, req1-only traffic is granted and req0 wins the next contention.

Source files
------------

// File: rtl/alu16_arbiter.sv
// ---------------------------------------------------------------------------
// alu16_arbiter
//
// Purpose:
//    Shares a single add/sub/and/or datapath between two requesters. A
//    round-robin arbiter accepts one command at a time over valid/ready
//    channels. The operands are registered, the result is computed in one
//    execute cycle, and the result is then held on a tagged response
//    channel until the consumer accepts it.
//
// Optional feature (macro ALU_FLAGS_EN):
//    When defined, adds rsp_zero, rsp_neg and rsp_carry outputs. They are
//    registered together with rsp_data and held with it.
//
// Ports:
//    clk                 system clock, rising edge
//    rst_n               asynchronous active-low reset
//    req0_valid/ready    requester 0 command handshake
//    req0_a/b/op         requester 0 operands and op (00 add, 01 sub, 10 and, 11 or)
//    req1_valid/ready    requester 1 command handshake
//    req1_a/b/op         requester 1 operands and op
//    rsp_valid/ready     response handshake
//    rsp_data            result
//    rsp_id              index of the requester that issued the result
//    busy                high whenever a command is in flight
//    rsp_zero/neg/carry  result flags (ALU_FLAGS_EN only)
// ---------------------------------------------------------------------------
module alu16_arbiter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [1:0]   req0_op,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [1:0]   req1_op,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_data,
   output logic         rsp_id,
   output logic         busy
`ifdef ALU_FLAGS_EN
   ,
   output logic         rsp_zero,
   output logic         rsp_neg,
   output logic         rsp_carry
`endif
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]   state_q, state_d;
   logic         lastGrant_q, lastGrant_d;
   logic [W-1:0] opA_q, opA_d;
   logic [W-1:0] opB_q, opB_d;
   logic [1:0]   opCode_q, opCode_d;
   logic         id_q, id_d;
   logic         rspValid_q, rspValid_d;
   logic [W-1:0] rspData_q, rspData_d;
   logic         rspId_q, rspId_d;

   logic         grantValid;
   logic         grantId;
   logic         accept;
   logic [W-1:0] aluResult;

`ifdef ALU_FLAGS_EN
   logic         aluCarry;
   logic         zero_q, zero_d;
   logic         neg_q, neg_d;
   logic         carry_q, carry_d;
`endif

   // Round-robin grant: a lone requester always wins; under contention the
   // requester that was not granted last time wins, so contended grants
   // strictly alternate.
   always_comb begin
      grantValid = 1'b0;
      grantId    = 1'b0;
      if (req0_valid && req1_valid) begin
         grantValid = 1'b1;
         grantId    = ~lastGrant_q;
      end else if (req0_valid) begin
         grantValid = 1'b1;
         grantId    = 1'b0;
      end else if (req1_valid) begin
         grantValid = 1'b1;
         grantId    = 1'b1;
      end
   end

   // Ready is combinational from valid and only asserted in IDLE, so a
   // requester can withdraw its command before acceptance at no cost.
   assign accept     = (state_q == IDLE) && grantValid;
   assign req0_ready = accept && (grantId == 1'b0);
   assign req1_ready = accept && (grantId == 1'b1);

   // The ALU works only on the registered operands so that input changes
   // after acceptance cannot leak into the result. The flags build keeps
   // one extra bit to expose the carry out; subtraction is a + ~b + 1 so
   // its carry means "no borrow".
`ifdef ALU_FLAGS_EN
   always_comb begin
      aluResult = '0;
      aluCarry  = 1'b0;
      case (opCode_q)
         2'b00:   {aluCarry, aluResult} = {1'b0, opA_q} + {1'b0, opB_q};
         2'b01:   {aluCarry, aluResult} = {1'b0, opA_q} + {1'b0, ~opB_q} + {{W{1'b0}}, 1'b1};
         2'b10:   aluResult = opA_q & opB_q;
         default: aluResult = opA_q | opB_q;
      endcase
   end
`else
   always_comb begin
      aluResult = '0;
      case (opCode_q)
         2'b00:   aluResult = opA_q + opB_q;
         2'b01:   aluResult = opA_q + ~opB_q + {{(W-1){1'b0}}, 1'b1};
         2'b10:   aluResult = opA_q & opB_q;
         default: aluResult = opA_q | opB_q;
      endcase
   end
`endif

   // Sequencer: IDLE accepts one command, EXEC computes it in a single
   // cycle, RESP holds the response until the consumer takes it. rsp_ready
   // is ignored outside RESP.
   always_comb begin
      state_d     = state_q;
      lastGrant_d = lastGrant_q;
      opA_d       = opA_q;
      opB_d       = opB_q;
      opCode_d    = opCode_q;
      id_d        = id_q;
      rspValid_d  = rspValid_q;
      rspData_d   = rspData_q;
      rspId_d     = rspId_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               opA_d       = grantId ? req1_a  : req0_a;
               opB_d       = grantId ? req1_b  : req0_b;
               opCode_d    = grantId ? req1_op : req0_op;
               id_d        = grantId;
               lastGrant_d = grantId;
               state_d     = EXEC;
            end
         end
         EXEC: begin
            rspData_d  = aluResult;
            rspId_d    = id_q;
            rspValid_d = 1'b1;
            state_d    = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rspValid_d = 1'b0;
               state_d    = IDLE;
            end
         end
         default: begin
            rspValid_d = 1'b0;
            state_d    = IDLE;
         end
      endcase
   end

   // State registers. lastGrant resets to 1 so that requester 0 wins the
   // first contention; reset discards any in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         opA_q       <= '0;
         opB_q       <= '0;
         opCode_q    <= 2'b00;
         id_q        <= 1'b0;
         rspValid_q  <= 1'b0;
         rspData_q   <= '0;
         rspId_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         lastGrant_q <= lastGrant_d;
         opA_q       <= opA_d;
         opB_q       <= opB_d;
         opCode_q    <= opCode_d;
         id_q        <= id_d;
         rspValid_q  <= rspValid_d;
         rspData_q   <= rspData_d;
         rspId_q     <= rspId_d;
      end
   end

`ifdef ALU_FLAGS_EN
   // Flags are captured in the same EXEC cycle as the result and held with
   // it; carry is only meaningful for add and sub.
   always_comb begin
      zero_d  = zero_q;
      neg_d   = neg_q;
      carry_d = carry_q;
      if (state_q == EXEC) begin
         zero_d  = (aluResult == '0);
         neg_d   = aluResult[W-1];
         carry_d = aluCarry;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q  <= 1'b0;
         neg_q   <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         zero_q  <= zero_d;
         neg_q   <= neg_d;
         carry_q <= carry_d;
      end
   end

   assign rsp_zero  = zero_q;
   assign rsp_neg   = neg_q;
   assign rsp_carry = carry_q;
`endif

   assign rsp_valid = rspValid_q;
   assign rsp_data  = rspData_q;
   assign rsp_id    = rspId_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu16_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu16_arbiter
//
// Self-checking bench for alu16_arbiter. Directed sequences and random
// traffic are driven one cycle at a time; a queue-based reference model
// predicts grants, ready, busy and every response.
// ---------------------------------------------------------------------------
module tb_alu16_arbiter;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         req0_valid, req0_ready;
   logic [W-1:0] req0_a, req0_b;
   logic [1:0]   req0_op;
   logic         req1_valid, req1_ready;
   logic [W-1:0] req1_a, req1_b;
   logic [1:0]   req1_op;
   logic         rsp_valid, rsp_ready;
   logic [W-1:0] rsp_data;
   logic         rsp_id;
   logic         busy;
`ifdef ALU_FLAGS_EN
   logic         rsp_zero, rsp_neg, rsp_carry;
`endif

   alu16_arbiter #(.W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
`ifdef ALU_FLAGS_EN
      ,
      .rsp_zero   (rsp_zero),
      .rsp_neg    (rsp_neg),
      .rsp_carry  (rsp_carry)
`endif
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        id;
      logic        carry;
      int          accCycle;
   } rsp_t;

   rsp_t pending[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cycleNum    = 0;
   logic lastGrant   = 1'b1;

   // Single comparison point: counts every comparison and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycleNum);
      end
   endtask

   // Reference ALU with plain integer arithmetic; returns {carry, result}.
   function automatic logic [16:0] refAlu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
      int s;
      logic [15:0] d;
      case (op)
         2'b00: begin
            s = int'(a) + int'(b);
            d = 16'(s % 65536);
            return {(s >= 65536), d};
         end
         2'b01: begin
            s = int'(a) - int'(b);
            d = 16'((s + 65536) % 65536);
            return {(int'(a) >= int'(b)), d};
         end
         2'b10:   return {1'b0, a & b};
         default: return {1'b0, a | b};
      endcase
   endfunction

   // Drives one clock cycle of inputs, checks the DUT against the model
   // and then advances the model to what the next rising edge does.
   task automatic applyStimulus(input logic v0, input logic [15:0] a0, input logic [15:0] b0, input logic [1:0] o0,
                                input logic v1, input logic [15:0] a1, input logic [15:0] b1, input logic [1:0] o1,
                                input logic rr);
      logic expBusy, expValid, expR0, expR1;
      logic [16:0] r;
      rsp_t e;
      @(negedge clk);
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = o0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = o1;
      rsp_ready  = rr;
      #1;
      expBusy  = (pending.size() != 0);
      expValid = expBusy && (cycleNum >= pending[0].accCycle + 2);
      expR0    = !expBusy && v0 && (!v1 || lastGrant == 1'b1);
      expR1    = !expBusy && v1 && (!v0 || lastGrant == 1'b0);
      checkOutput("req0_ready", req0_ready, expR0);
      checkOutput("req1_ready", req1_ready, expR1);
      checkOutput("busy", busy, expBusy);
      checkOutput("rsp_valid", rsp_valid, expValid);
      if (expValid) begin
         checkOutput("rsp_data", rsp_data, pending[0].data);
         checkOutput("rsp_id", rsp_id, pending[0].id);
`ifdef ALU_FLAGS_EN
         checkOutput("rsp_zero", rsp_zero, (pending[0].data == 16'h0000));
         checkOutput("rsp_neg", rsp_neg, (pending[0].data >= 16'h8000));
         checkOutput("rsp_carry", rsp_carry, pending[0].carry);
`endif
      end
      if (expValid && rr) void'(pending.pop_front());
      if (expR0 || expR1) begin
         r = expR1 ? refAlu(o1, a1, b1) : refAlu(o0, a0, b0);
         e.data     = r[15:0];
         e.carry    = r[16];
         e.id       = expR1;
         e.accCycle = cycleNum;
         pending.push_back(e);
         lastGrant = expR1;
      end
      cycleNum++;
   endtask

   // Idle cycle helper.
   task automatic idleCycle(input logic rr);
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, rr);
   endtask

   // Synchronous-looking reset pulse with output checks while held.
   task automatic doReset();
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
      checkOutput("reset_rsp_data", rsp_data, 16'h0000);
      checkOutput("reset_rsp_id", rsp_id, 1'b0);
      checkOutput("reset_busy", busy, 1'b0);
      pending.delete();
      lastGrant = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 2'b00;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 2'b00;
      rsp_ready = 1'b0;

      $display("[TB] reset and single add");
      doReset();
      applyStimulus(1'b1, 16'h1234, 16'h0FED, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("plan_add_data", rsp_data, 16'h2221);
      idleCycle(1'b1);

      $display("[TB] contention alternation");
      doReset();
      for (int i = 0; i < 12; i++)
         applyStimulus(1'b1, 16'h0000, 16'h0001, 2'b01, 1'b1, 16'hF0F0, 16'h0F0F, 2'b11, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);

      $display("[TB] backpressure");
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'hFF00, 16'h0FF0, 2'b10, 1'b0);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 16'h1111, 16'h2222, 2'b00, 1'b1, 16'h3333, 16'h4444, 2'b00, 1'b0);
      checkOutput("plan_bp_data", rsp_data, 16'h0F00);
      idleCycle(1'b1);
      idleCycle(1'b1);

      $display("[TB] wrap and operand change");
      applyStimulus(1'b1, 16'hFFFF, 16'h0001, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("plan_wrap_data", rsp_data, 16'h0000);
      applyStimulus(1'b1, 16'h0005, 16'h0003, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      applyStimulus(1'b1, 16'h0009, 16'h0009, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      applyStimulus(1'b1, 16'h0009, 16'h0009, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      checkOutput("plan_first_data", rsp_data, 16'h0008);
      applyStimulus(1'b1, 16'h0009, 16'h0009, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0, 16'h0, 2'b00, 1'b1);
      checkOutput("plan_second_data", rsp_data, 16'h0012);
      idleCycle(1'b1);

      $display("[TB] random traffic");
      for (int i = 0; i < 500; i++) begin
         logic [15:0] ra0, rb0, ra1, rb1;
         ra0 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         rb0 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         ra1 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         rb1 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         applyStimulus(1'($urandom_range(0, 1)), ra0, rb0, 2'($urandom),
                       1'($urandom_range(0, 1)), ra1, rb1, 2'($urandom),
                       ($urandom_range(0, 9) < 6));
      end
      for (int i = 0; i < 8; i++) idleCycle(1'b1);

      $display("[TB] reset during response");
      applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h00AA, 16'h0055, 2'b11, 1'b0);
      idleCycle(1'b0);
      idleCycle(1'b0);
      idleCycle(1'b0);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checkOutput("midreset_rsp_valid", rsp_valid, 1'b0);
      checkOutput("midreset_rsp_data", rsp_data, 16'h0000);
      checkOutput("midreset_busy", busy, 1'b0);
      pending.delete();
      lastGrant = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++)
         applyStimulus(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0100, 16'h0001, 2'b01, 1'b1);
      for (int i = 0; i < 6; i++)
         applyStimulus(1'b1, 16'h7FFF, 16'h0001, 2'b00, 1'b1, 16'h8000, 16'h8000, 2'b00, 1'b1);
      for (int i = 0; i < 4; i++) idleCycle(1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
